// File: rtl/arith_sequencer.sv
// -----------------------------------------------------------------------------
// arith_sequencer
// Central control FSM for the shared iterative arithmetic units (shift-add
// multiplier, restoring divider, bit-serial square root). It accepts one
// operation at a time and walks the selected unit through its load, iterate
// and finish phases. The datapaths live in the units; this block only
// sequences them.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      request strobe, sampled only in IDLE
//   op         00 mul, 01 div, 10 sqrt, 11 illegal
//   abort      cancel the operation in flight (sampled in LOAD and RUN)
//   mul_ctrl   {load, enable, sync_rst, ready, ctrl_stop}
//   div_ctrl   {load, shift, sync_rst, ready, ctrl_stop}
//   sqrt_ctrl  {enable, controlEND, synch, ready, ctrl_stop}
//   active_op  op latched at accept, held until the next accept
//   busy       high in every state except IDLE
//   done       one-cycle pulse on normal completion
//   err        one-cycle pulse when an illegal op is rejected
// -----------------------------------------------------------------------------
module arith_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
  output logic [4:0] mul_ctrl,
  output logic [4:0] div_ctrl,
  output logic [4:0] sqrt_ctrl,
  output logic [1:0] active_op,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // Counter preload is N-1 so that RUN covers counter values N-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WIDTH / 2 - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       aop_reg, aop_next;
  logic             busy_reg, done_reg, err_reg;
  logic             err_next;

  // Phase decode of the *next* state; outputs are registered from these so
  // that each output lines up with the state it belongs to.
  logic load_ph, run_ph, last_ph, done_ph, abort_ph;

  logic [4:0] unit_vec [3];
  logic [4:0] ctrl_next [3];
  logic [4:0] ctrl_reg [3];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      aop_reg   <= 2'b00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      aop_reg   <= aop_next;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= done_ph;
      err_reg   <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    aop_next   = aop_reg;
    err_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (op == OP_ILL) begin
            err_next = 1'b1;
          end else begin
            aop_next   = op;
            cnt_next   = (op == OP_SQRT) ? CNT_HALF : CNT_FULL;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_next = abort ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        // Abort outranks completion, including on the final iteration.
        if (abort) begin
          state_next = S_ABORT;
        end else if (cnt_reg == '0) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-unit control vectors
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ph  = (state_next == S_LOAD);
    run_ph   = (state_next == S_RUN);
    last_ph  = (state_next == S_RUN) && (cnt_next == '0);
    done_ph  = (state_next == S_DONE);
    abort_ph = (state_next == S_ABORT);

    // mul: {load, enable, sync_rst, ready, ctrl_stop}
    unit_vec[0] = {load_ph, run_ph, abort_ph, done_ph, abort_ph};
    // div: {load, shift, sync_rst, ready, ctrl_stop}
    unit_vec[1] = {load_ph, run_ph, abort_ph, done_ph, abort_ph};
    // sqrt: {enable, controlEND, synch, ready, ctrl_stop}; synch serves both
    // as the operand-capture strobe and as the abort-time reset.
    unit_vec[2] = {run_ph, last_ph, load_ph | abort_ph, done_ph, abort_ph};
  end

  // Only the unit matching the latched op sees a non-zero vector.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unit
      assign ctrl_next[gi] = (aop_next == 2'(gi)) ? unit_vec[gi] : 5'b00000;

      always_ff @(posedge clk) begin
        if (reset) begin
          ctrl_reg[gi] <= 5'b00000;
        end else begin
          ctrl_reg[gi] <= ctrl_next[gi];
        end
      end
    end
  endgenerate

  assign mul_ctrl  = ctrl_reg[0];
  assign div_ctrl  = ctrl_reg[1];
  assign sqrt_ctrl = ctrl_reg[2];
  assign active_op = aop_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_arith_sequencer.sv
module tb_arith_sequencer;

  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic       abort;
  logic [4:0] mul_ctrl, div_ctrl, sqrt_ctrl;
  logic [1:0] active_op;
  logic       busy, done, err;

  int checks_total = 0;
  int checks_passed = 0;

  logic [19:0] exp_q [$];
  logic [1:0]  last_aop;

  arith_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .abort     (abort),
    .mul_ctrl  (mul_ctrl),
    .div_ctrl  (div_ctrl),
    .sqrt_ctrl (sqrt_ctrl),
    .active_op (active_op),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Packed view: {mul, div, sqrt, active_op, busy, done, err}
  function automatic logic [19:0] mk(input logic [1:0] u, input logic [4:0] v,
                                     input logic [1:0] a, input logic b,
                                     input logic d, input logic e);
    logic [4:0] m, dv, s;
    m  = (u == 2'd0) ? v : 5'b0;
    dv = (u == 2'd1) ? v : 5'b0;
    s  = (u == 2'd2) ? v : 5'b0;
    return {m, dv, s, a, b, d, e};
  endfunction

  function automatic logic [4:0] load_vec(input logic [1:0] u);
    return (u == 2'd2) ? 5'b00100 : 5'b10000;
  endfunction

  function automatic logic [4:0] run_vec(input logic [1:0] u, input logic last);
    if (u == 2'd2) return last ? 5'b11000 : 5'b10000;
    return 5'b01000;
  endfunction

  task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    checks_total++;
    if (obs !== expv)
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    else
      checks_passed++;
  endtask

  // Drive inputs for one cycle, queue the output expected after the edge,
  // then pop and compare once the DUT has produced it.
  task automatic drive(input logic s, input logic [1:0] o, input logic a,
                       input logic r, input logic [19:0] e, input string tag);
    start = s; op = o; abort = a; reset = r;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_eq(tag, {mul_ctrl, div_ctrl, sqrt_ctrl, active_op, busy, done, err},
             exp_q.pop_front());
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 2'b00, 1'b0, 1'b0, mk(2'd0, 5'b0, last_aop, 1'b0, 1'b0, 1'b0), tag);
  endtask

  // abort_c / reset_c: call index (1 = during LOAD, c = during RUN c-1) at
  // which abort / reset is driven; 0 means never.
  task automatic run_op(input logic [1:0] o, input int abort_c, input int reset_c,
                        input logic hold, input logic acc_abort);
    int n;
    logic [1:0] junk;
    n = (o == 2'd2) ? WIDTH / 2 : WIDTH;
    junk = o ^ 2'b01;
    drive(1'b1, o, acc_abort, 1'b0, mk(o, load_vec(o), o, 1'b1, 1'b0, 1'b0), "load");
    last_aop = o;
    for (int c = 1; c <= n + 1; c++) begin
      if (c == reset_c) begin
        drive(hold, junk, 1'b0, 1'b1, 20'h0, "reset_mid");
        last_aop = 2'b00;
        idle("after_reset");
        idle("after_reset2");
        $display("op %0d reset at call %0d", o, c);
        return;
      end
      if (c == abort_c) begin
        drive(hold, junk, 1'b1, 1'b0, mk(o, 5'b00101, o, 1'b1, 1'b0, 1'b0), "abort");
        idle("after_abort");
        $display("op %0d aborted at call %0d", o, c);
        return;
      end
      if (c <= n)
        drive(hold, junk, 1'b0, 1'b0, mk(o, run_vec(o, c == n), o, 1'b1, 1'b0, 1'b0), "run");
      else
        drive(hold, junk, 1'b0, 1'b0, mk(o, 5'b00010, o, 1'b1, 1'b1, 1'b0), "done");
    end
    // In DONE: start and abort must both be ignored.
    drive(hold, junk, 1'b1, 1'b0, mk(o, 5'b0, o, 1'b0, 1'b0, 1'b0), "post_done");
    $display("op %0d completed", o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; op = 2'b00; abort = 1'b0; reset = 1'b1;
    last_aop = 2'b00;
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 20'h0, "reset_state");
    drive(1'b1, 2'b01, 1'b1, 1'b1, 20'h0, "reset_state2");
    idle("idle");
    drive(1'b0, 2'b00, 1'b1, 1'b0, mk(2'd0, 5'b0, last_aop, 1'b0, 1'b0, 1'b0), "idle_abort");

    run_op(2'd0, 0, 0, 1'b0, 1'b0);            // mul, full run
    run_op(2'd2, 0, 0, 1'b0, 1'b0);            // sqrt, full run
    run_op(2'd1, 6, 0, 1'b0, 1'b0);            // div, abort in 5th RUN cycle
    run_op(2'd0, 0, 0, 1'b0, 1'b0);            // fresh mul after abort

    drive(1'b1, 2'b11, 1'b0, 1'b0, mk(2'd0, 5'b0, last_aop, 1'b0, 1'b0, 1'b1), "illegal");
    idle("illegal_after");
    $display("illegal op rejected");

    run_op(2'd1, 0, 0, 1'b1, 1'b0);            // div with start/op=00 held
    run_op(2'd0, 0, 0, 1'b0, 1'b0);            // back-to-back accept

    run_op(2'd0, 0, 4, 1'b0, 1'b0);            // reset in RUN cycle 3
    run_op(2'd1, 0, 0, 1'b0, 1'b0);            // full div afterwards

    run_op(2'd2, 0, 0, 1'b0, 1'b1);            // start+abort in IDLE accepted
    run_op(2'd2, WIDTH / 2 + 1, 0, 1'b0, 1'b0); // abort on final RUN cycle
    run_op(2'd1, 1, 0, 1'b0, 1'b0);            // abort in LOAD

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
